// File: rtl/serializer_pkg.sv
// Shared types and constants for the bit serializer slice.
package serializer_pkg;

    localparam int unsigned SER_WIDTH_DEF = 8;

    typedef enum logic [0:0] {S_IDLE, S_SHIFT} ser_state_e;

    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/ser_hold_buf.sv
// One-entry skid register: parks the next word while the current one is still shifting.
module ser_hold_buf
    import serializer_pkg::*;
#(
    parameter int unsigned WIDTH = SER_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             load,
    input  logic             drain,
    output logic [WIDTH-1:0] hold_data,
    output logic             hold_full,
    output logic             in_ready
);

    logic [WIDTH-1:0] hold_reg_q, hold_reg_d;
    logic             hold_full_q, hold_full_d;

    // load and drain are mutually exclusive: load needs a non-finishing word, drain a finishing one
    always_comb begin
        hold_reg_d  = hold_reg_q;
        hold_full_d = hold_full_q;
        if (drain) begin
            hold_full_d = 1'b0;
        end else if (load) begin
            hold_reg_d  = in_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_reg_q  <= '0;
            hold_full_q <= 1'b0;
        end else begin
            hold_reg_q  <= hold_reg_d;
            hold_full_q <= hold_full_d;
        end
    end

    assign hold_data = hold_reg_q;
    assign hold_full = hold_full_q;
    assign in_ready  = !hold_full_q;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: WIDTH-bit words in over valid/ready, one bit per enabled clock out.
module bit_serializer
    import serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = SER_WIDTH_DEF,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    localparam int unsigned     CntW    = cnt_w(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;

    logic             active, accept, finishing;
    logic             hold_load, hold_drain, hold_full;
    logic [WIDTH-1:0] hold_data;

    assign active     = (state_q == S_SHIFT);
    assign accept     = in_valid && in_ready;
    assign finishing  = active && en && (bit_cnt_q == LastCnt);
    assign hold_load  = active && !finishing && accept;
    assign hold_drain = finishing && hold_full;

    ser_hold_buf #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .load     (hold_load),
        .drain    (hold_drain),
        .hold_data(hold_data),
        .hold_full(hold_full),
        .in_ready (in_ready)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    shift_d   = in_data;
                    bit_cnt_d = '0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (finishing) begin
                    // Held word wins; otherwise a fresh word can go straight into the shifter
                    if (hold_full) begin
                        shift_d   = hold_data;
                        bit_cnt_d = '0;
                    end else if (accept) begin
                        shift_d   = in_data;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (en) begin
                    shift_d   = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0}
                                          : {1'b0, shift_q[WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + CntW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign ser_valid = active;
    assign ser_out   = active ? (MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0]) : IDLE_BIT;
    assign ser_last  = active && (bit_cnt_q == LastCnt);
    assign busy      = active || hold_full;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: one MSB-first and one LSB-first instance.
module tb_bit_serializer;
    import serializer_pkg::*;

    localparam int W = SER_WIDTH_DEF;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en;
    logic [W-1:0] m_data, l_data;
    logic         m_valid, l_valid;
    logic         m_ready, m_ser, m_sv, m_sl, m_busy;
    logic         l_ready, l_ser, l_sv, l_sl, l_busy;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
        .clk(clk), .rst(rst), .in_data(m_data), .in_valid(m_valid), .in_ready(m_ready),
        .en(en), .ser_out(m_ser), .ser_valid(m_sv), .ser_last(m_sl), .busy(m_busy)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
        .clk(clk), .rst(rst), .in_data(l_data), .in_valid(l_valid), .in_ready(l_ready),
        .en(en), .ser_out(l_ser), .ser_valid(l_sv), .ser_last(l_sl), .busy(l_busy)
    );

    function automatic void push_word(input logic [W-1:0] d, input bit msb);
        for (int i = 0; i < W; i++) begin
            exp_t e;
            e.b    = msb ? d[W-1-i] : d[i];
            e.last = (i == W - 1);
            sb_q.push_back(e);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        en = 1'b1; m_valid = 1'b0; l_valid = 1'b0; m_data = '0; l_data = '0;
        rst = 1'b0;
        #2;
        checks++;
        if (m_ser !== 1'b0 || m_sv !== 1'b0 || m_sl !== 1'b0 || m_ready !== 1'b1 || m_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_msb: out/valid/last/ready/busy=%b%b%b%b%b required 00010",
                     m_ser, m_sv, m_sl, m_ready, m_busy);
        end
        checks++;
        if (l_ser !== 1'b0 || l_sv !== 1'b0 || l_sl !== 1'b0 || l_ready !== 1'b1 || l_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_lsb: out/valid/last/ready/busy=%b%b%b%b%b required 00010",
                     l_ser, l_sv, l_sl, l_ready, l_busy);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_msb_single();
        logic [W-1:0] d = 8'b0100_1101;
        int nvalid = 0;
        exp_t e;
        sb_q.delete();
        m_data = d; m_valid = 1'b1; en = 1'b1;
        push_word(d, 1'b1);
        for (int k = 0; k <= W; k++) begin
            tick();
            m_valid = 1'b0;
            if (m_sv === 1'b1) begin
                nvalid++;
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL msb_bit k=%0d: got extra bit %b, required none", k, m_ser);
                end else begin
                    e = sb_q.pop_front();
                    if (m_ser !== e.b || m_sl !== e.last) begin
                        failures++;
                        $display("FAIL msb_bit k=%0d: out=%b last=%b required out=%b last=%b",
                                 k, m_ser, m_sl, e.b, e.last);
                    end
                end
            end
        end
        checks++;
        if (nvalid != W) begin
            failures++;
            $display("FAIL msb_valid_count: got %0d required %0d", nvalid, W);
        end
        checks++;
        if (m_ser !== 1'b0 || m_busy !== 1'b0) begin
            failures++;
            $display("FAIL msb_idle_after: out=%b busy=%b required 0 0", m_ser, m_busy);
        end
    endtask

    task automatic test_lsb();
        logic [W-1:0] d = 8'hA5;
        int nvalid = 0;
        exp_t e;
        sb_q.delete();
        l_data = d; l_valid = 1'b1; en = 1'b1;
        push_word(d, 1'b0);
        for (int k = 0; k <= W; k++) begin
            tick();
            l_valid = 1'b0;
            if (l_sv === 1'b1) begin
                nvalid++;
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL lsb_bit k=%0d: got extra bit %b, required none", k, l_ser);
                end else begin
                    e = sb_q.pop_front();
                    if (l_ser !== e.b || l_sl !== e.last) begin
                        failures++;
                        $display("FAIL lsb_bit k=%0d: out=%b last=%b required out=%b last=%b",
                                 k, l_ser, l_sl, e.b, e.last);
                    end
                end
            end
        end
        checks++;
        if (nvalid != W || l_ser !== 1'b0) begin
            failures++;
            $display("FAIL lsb_count_idle: valid=%0d out=%b required %0d 0", nvalid, l_ser, W);
        end
    endtask

    task automatic test_back_to_back();
        int nvalid = 0;
        logic ready_exp;
        exp_t e;
        sb_q.delete();
        m_data = 8'hF0; m_valid = 1'b1; en = 1'b1;
        push_word(8'hF0, 1'b1);
        for (int k = 0; k <= 2 * W; k++) begin
            tick();
            ready_exp = !(k >= 1 && k <= 7);
            checks++;
            if (m_ready !== ready_exp) begin
                failures++;
                $display("FAIL b2b_ready k=%0d: got %b required %b", k, m_ready, ready_exp);
            end
            if (k < 2 * W) begin
                checks++;
                if (m_sv !== 1'b1 || sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_gap k=%0d: valid=%b required 1", k, m_sv);
                end else begin
                    e = sb_q.pop_front();
                    nvalid++;
                    if (m_ser !== e.b || m_sl !== e.last) begin
                        failures++;
                        $display("FAIL b2b_bit k=%0d: out=%b last=%b required out=%b last=%b",
                                 k, m_ser, m_sl, e.b, e.last);
                    end
                end
            end else begin
                checks++;
                if (m_sv !== 1'b0 || m_busy !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_end: valid=%b busy=%b required 0 0", m_sv, m_busy);
                end
            end
            if (k == 0) begin
                m_data = 8'h0F;
                push_word(8'h0F, 1'b1);
            end
            // Offered while the hold is full; must never be taken
            if (k == 1) m_data = 8'hAA;
            if (k == 7) m_valid = 1'b0;
        end
        checks++;
        if (nvalid != 2 * W) begin
            failures++;
            $display("FAIL b2b_count: got %0d required %0d", nvalid, 2 * W);
        end
    endtask

    task automatic test_stall();
        int nvalid = 0;
        logic en_edge;
        bit cur_v = 1'b0;
        exp_t cur = '0;
        sb_q.delete();
        m_data = 8'hC3; m_valid = 1'b1; en = 1'b1;
        push_word(8'hC3, 1'b1);
        for (int k = 0; k < 12; k++) begin
            en_edge = en;
            tick();
            m_valid = 1'b0;
            if (k == 0 || en_edge) begin
                cur_v = (sb_q.size() != 0);
                if (cur_v) cur = sb_q.pop_front();
            end
            if (m_sv === 1'b1) nvalid++;
            checks++;
            if (m_sv !== cur_v || (cur_v && (m_ser !== cur.b || m_sl !== cur.last))) begin
                failures++;
                $display("FAIL stall k=%0d: valid=%b out=%b last=%b required valid=%b out=%b last=%b",
                         k, m_sv, m_ser, m_sl, cur_v, cur.b, cur.last);
            end
            if (k == 3) en = 1'b0;
            if (k == 6) en = 1'b1;
        end
        checks++;
        if (nvalid != 11) begin
            failures++;
            $display("FAIL stall_count: got %0d required 11", nvalid);
        end
    endtask

    task automatic test_reset_mid();
        int nvalid = 0;
        sb_q.delete();
        m_data = 8'hFF; m_valid = 1'b1; en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            m_valid = 1'b0;
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (m_sv !== 1'b0 || m_ser !== 1'b0 || m_ready !== 1'b1 || m_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: valid=%b out=%b ready=%b busy=%b required 0 0 1 0",
                     m_sv, m_ser, m_ready, m_busy);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (m_sv === 1'b1 || m_ser !== 1'b0) nvalid++;
        end
        checks++;
        if (nvalid != 0) begin
            failures++;
            $display("FAIL reset_residual: got %0d active cycles required 0", nvalid);
        end
    endtask

    task automatic test_chain();
        logic [W-1:0] d = 8'b0010_0110;
        logic prev_exp = 1'b0, prev_obs = 1'b0;
        logic exp_b, exp_y, obs_y;
        int rises_obs = 0, rises_exp = 0;
        exp_t e;
        for (int i = W - 1; i >= 0; i--) begin
            if (d[i] && (i == W - 1 || !d[i+1])) rises_exp++;
        end
        sb_q.delete();
        m_data = d; m_valid = 1'b1; en = 1'b1;
        push_word(d, 1'b1);
        for (int k = 0; k <= W; k++) begin
            tick();
            m_valid = 1'b0;
            exp_b = 1'b0;
            if (k < W) begin
                e = sb_q.pop_front();
                exp_b = e.b;
            end
            exp_y = exp_b & ~prev_exp;
            obs_y = m_ser & ~prev_obs;
            prev_exp = exp_b;
            prev_obs = m_ser;
            if (obs_y === 1'b1) rises_obs++;
            checks++;
            if (obs_y !== exp_y || m_sv !== (k < W)) begin
                failures++;
                $display("FAIL chain k=%0d: y=%b valid=%b required y=%b valid=%b",
                         k, obs_y, m_sv, exp_y, (k < W));
            end
        end
        checks++;
        if (rises_obs != rises_exp) begin
            failures++;
            $display("FAIL chain_rises: got %0d required %0d", rises_obs, rises_exp);
        end
    endtask

    initial begin
        test_reset();
        test_msb_single();
        test_lsb();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_chain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
